// File: rtl/bus_rr_arbiter_if.sv
// bus_rr_arbiter_if
//   Groups the request/grant/bus signals of the round-robin bus arbiter.
//   master : arbiter side. It takes the requests and the slave ready strobe,
//            and drives the grant vector and the bus request to the slave.
//   slave  : requester / bus-slave side (the masters' DMA lines and BUS_ready).
//   Signals:
//     DMA       [N]     level request per master
//     BUS_ready         slave ready/ack strobe for the current owner
//     grant     [N]     one-hot (or zero) registered grant
//     BUS_req           registered, equals |grant
//     owner     [ID_W]  index of current/last owner
//     bus_err           one-cycle pulse when the watchdog revokes a grant
//     err_id    [ID_W]  index of the master revoked by the last timeout
interface bus_rr_arbiter_if #(
  parameter int N    = 8,
  parameter int ID_W = 3
);
  logic [N-1:0]    DMA;
  logic            BUS_ready;
  logic [N-1:0]    grant;
  logic            BUS_req;
  logic [ID_W-1:0] owner;
  logic            bus_err;
  logic [ID_W-1:0] err_id;

  modport master (
    input  DMA, BUS_ready,
    output grant, BUS_req, owner, bus_err, err_id
  );

  modport slave (
    output DMA, BUS_ready,
    input  grant, BUS_req, owner, bus_err, err_id
  );
endinterface

// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter
//   Round-robin arbiter for the shared system bus. One owner at a time, a
//   one-cycle turnaround (TURN) between owners, and a watchdog that revokes
//   a grant after TIMEOUT consecutive cycles without BUS_ready. A revoked
//   master is masked until it drops its request.
//   Ports:
//     clk    in  system clock, rising edge
//     clr_n  in  asynchronous active-low reset
//     bus    master modport of bus_rr_arbiter_if (DMA, BUS_ready in;
//            grant, BUS_req, owner, bus_err, err_id out, all registered)
module bus_rr_arbiter #(
  parameter int N       = 8,
  parameter int ID_W    = 3,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              clr_n,
  bus_rr_arbiter_if.master  bus
);

  typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [N-1:0]    mask_q, mask_d, mask_set;
  logic            bus_req_q, bus_req_d;
  logic            bus_err_q, bus_err_d;
  logic [ID_W-1:0] owner_q, owner_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] err_id_q, err_id_d;
  logic [TO_W-1:0] wdog_q, wdog_d;

  logic [N-1:0]    dma, cand;
  logic [N-1:0]    hit;
  logic [ID_W-1:0] idx_at [N];
  logic            win_vld;
  logic [ID_W-1:0] win_id;

  assign dma  = bus.DMA;
  assign cand = dma & ~mask_q;

  // Slot gi of the search looks at requester (ptr+1+gi) mod N, so slot 0 is
  // the one right after the last owner and the last owner itself comes last.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
      logic [ID_W:0] sum;
      assign sum        = {1'b0, ptr_q} + (ID_W+1)'(gi + 1);
      assign idx_at[gi] = (sum >= (ID_W+1)'(N)) ? ID_W'(sum - (ID_W+1)'(N)) : ID_W'(sum);
      assign hit[gi]    = cand[idx_at[gi]];
    end
  endgenerate

  // Lowest search slot with a candidate wins.
  always_comb begin
    win_vld = |hit;
    win_id  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hit[i]) win_id = idx_at[i];
    end
  end

  // A mask bit is cleared whenever that master's request is low, so a
  // timed-out master must drop and re-raise DMA before it can win again.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_mask
      assign mask_d[gi] = dma[gi] & (mask_q[gi] | mask_set[gi]);
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    bus_req_d = bus_req_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    wdog_d    = wdog_q;
    err_id_d  = err_id_q;
    bus_err_d = 1'b0;
    mask_set  = '0;
    case (state_q)
      IDLE, TURN: begin
        grant_d   = '0;
        bus_req_d = 1'b0;
        state_d   = IDLE;
        if (win_vld) begin
          grant_d[win_id] = 1'b1;
          bus_req_d       = 1'b1;
          owner_d         = win_id;
          wdog_d          = '0;
          state_d         = OWN;
        end
      end
      OWN: begin
        if (!dma[owner_q]) begin
          // Release takes precedence over a timeout on the same edge.
          grant_d   = '0;
          bus_req_d = 1'b0;
          ptr_d     = owner_q;
          state_d   = TURN;
        end else if (!bus.BUS_ready && wdog_q == TO_W'(TIMEOUT - 1)) begin
          grant_d           = '0;
          bus_req_d         = 1'b0;
          bus_err_d         = 1'b1;
          err_id_d          = owner_q;
          mask_set[owner_q] = 1'b1;
          ptr_d             = owner_q;
          state_d           = TURN;
        end else if (bus.BUS_ready) begin
          wdog_d = '0;
        end else if (wdog_q != '1) begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: begin
        grant_d   = '0;
        bus_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      bus_req_q <= 1'b0;
      bus_err_q <= 1'b0;
      err_id_q  <= '0;
      owner_q   <= '0;
      ptr_q     <= ID_W'(N - 1);
      wdog_q    <= '0;
      mask_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      bus_req_q <= bus_req_d;
      bus_err_q <= bus_err_d;
      err_id_q  <= err_id_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      wdog_q    <= wdog_d;
      mask_q    <= mask_d;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.BUS_req = bus_req_q;
  assign bus.owner   = owner_q;
  assign bus.bus_err = bus_err_q;
  assign bus.err_id  = err_id_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb_bus_rr_arbiter
//   Directed bench for bus_rr_arbiter (N=8, TIMEOUT=16). A table of
//   {DMA, BUS_ready, expected grant/owner} rows covers rotation, single
//   master, wrap-around and the one-cycle gap; hand-written sequences cover
//   the watchdog timeout, keepalive, release/timeout race and async reset.
module tb_bus_rr_arbiter;

  localparam int N    = 8;
  localparam int ID_W = 3;

  logic clk;
  logic clr_n;
  int   n_chk;
  int   n_fail;

  bus_rr_arbiter_if #(.N(N), .ID_W(ID_W)) bus_if ();

  bus_rr_arbiter #(.N(N), .ID_W(ID_W), .TIMEOUT(16), .TO_W(8)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dma;
    logic       rdy;
    logic [7:0] g;
    logic [2:0] own;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic [7:0] d, input logic [7:0] g, input int own);
    vec_t v;
    v.dma = d;
    v.rdy = 1'b1;
    v.g   = g;
    v.own = 3'(own);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;

    // rotation 85: 01,04,80,01 with one idle cycle between owners
    vt.push_back(mk(8'h85, 8'h01, 0)); vt.push_back(mk(8'h85, 8'h01, 0));
    vt.push_back(mk(8'h85, 8'h01, 0)); vt.push_back(mk(8'h85, 8'h01, 0));
    vt.push_back(mk(8'h84, 8'h00, 0)); vt.push_back(mk(8'h85, 8'h04, 2));
    vt.push_back(mk(8'h85, 8'h04, 2)); vt.push_back(mk(8'h85, 8'h04, 2));
    vt.push_back(mk(8'h85, 8'h04, 2)); vt.push_back(mk(8'h81, 8'h00, 2));
    vt.push_back(mk(8'h85, 8'h80, 7)); vt.push_back(mk(8'h85, 8'h80, 7));
    vt.push_back(mk(8'h85, 8'h80, 7)); vt.push_back(mk(8'h85, 8'h80, 7));
    vt.push_back(mk(8'h05, 8'h00, 7)); vt.push_back(mk(8'h85, 8'h01, 0));
    vt.push_back(mk(8'h84, 8'h00, 0)); vt.push_back(mk(8'h00, 8'h00, 0));
    vt.push_back(mk(8'h00, 8'h00, 0));
    // single master
    vt.push_back(mk(8'h01, 8'h01, 0)); vt.push_back(mk(8'h01, 8'h01, 0));
    vt.push_back(mk(8'h01, 8'h01, 0)); vt.push_back(mk(8'h01, 8'h01, 0));
    vt.push_back(mk(8'h00, 8'h00, 0)); vt.push_back(mk(8'h00, 8'h00, 0));
    // wrap after owner 7
    vt.push_back(mk(8'h80, 8'h80, 7)); vt.push_back(mk(8'h80, 8'h80, 7));
    vt.push_back(mk(8'h00, 8'h00, 7)); vt.push_back(mk(8'h41, 8'h01, 0));
    vt.push_back(mk(8'h41, 8'h01, 0)); vt.push_back(mk(8'h40, 8'h00, 0));
    vt.push_back(mk(8'h40, 8'h40, 6)); vt.push_back(mk(8'h00, 8'h00, 6));
    vt.push_back(mk(8'h00, 8'h00, 6));

    // reset state
    clr_n            = 1'b0;
    bus_if.DMA       = '0;
    bus_if.BUS_ready = 1'b0;
    tick();
    tick();
    chk("rst grant", bus_if.grant, 0);
    chk("rst req", bus_if.BUS_req, 0);
    chk("rst err", bus_if.bus_err, 0);
    chk("rst err_id", bus_if.err_id, 0);
    chk("rst owner", bus_if.owner, 0);
    @(negedge clk);
    clr_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      bus_if.DMA       = vt[i].dma;
      bus_if.BUS_ready = vt[i].rdy;
      tick();
      $display("vec %0d dma=%02h grant=%02h owner=%0d", i, vt[i].dma, bus_if.grant, bus_if.owner);
      chk($sformatf("v%0d grant", i), bus_if.grant, vt[i].g);
      chk($sformatf("v%0d req", i), bus_if.BUS_req, (vt[i].g != 0) ? 1 : 0);
      chk($sformatf("v%0d owner", i), bus_if.owner, vt[i].own);
      chk($sformatf("v%0d err", i), bus_if.bus_err, 0);
    end

    // watchdog timeout on master 3 (ptr=6 -> search 7,0,1,2,3)
    bus_if.DMA       = 8'h08;
    bus_if.BUS_ready = 1'b0;
    tick();
    chk("to grant0", bus_if.grant, 8'h08);
    for (int i = 1; i < 16; i++) begin
      tick();
      chk($sformatf("to grant%0d", i), bus_if.grant, 8'h08);
      chk($sformatf("to err%0d", i), bus_if.bus_err, 0);
    end
    tick();
    $display("timeout edge grant=%02h bus_err=%0d err_id=%0d", bus_if.grant, bus_if.bus_err, bus_if.err_id);
    chk("to revoke grant", bus_if.grant, 0);
    chk("to revoke req", bus_if.BUS_req, 0);
    chk("to bus_err", bus_if.bus_err, 1);
    chk("to err_id", bus_if.err_id, 3);
    tick();
    chk("to err pulse", bus_if.bus_err, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("to masked%0d", i), bus_if.grant, 0);
    end
    bus_if.DMA = 8'h00;
    tick();
    bus_if.DMA = 8'h08;
    tick();
    chk("to regrant", bus_if.grant, 8'h08);
    chk("to err_id hold", bus_if.err_id, 3);

    // keepalive: one BUS_ready pulse every 10 cycles
    for (int c = 0; c < 200; c++) begin
      bus_if.BUS_ready = (c % 10 == 0);
      tick();
      chk($sformatf("ka err%0d", c), bus_if.bus_err, 0);
      chk($sformatf("ka grant%0d", c), bus_if.grant, 8'h08);
    end
    $display("keepalive done grant=%02h", bus_if.grant);
    bus_if.DMA       = 8'h00;
    bus_if.BUS_ready = 1'b1;
    tick();
    chk("ka release", bus_if.grant, 0);
    tick();

    // release on the timeout edge: no bus_err (ptr=3 -> master 1 wins)
    bus_if.DMA       = 8'h02;
    bus_if.BUS_ready = 1'b0;
    tick();
    chk("race grant", bus_if.grant, 8'h02);
    for (int i = 1; i < 16; i++) tick();
    chk("race held", bus_if.grant, 8'h02);
    bus_if.DMA = 8'h00;
    tick();
    $display("race edge grant=%02h bus_err=%0d", bus_if.grant, bus_if.bus_err);
    chk("race grant0", bus_if.grant, 0);
    chk("race no err", bus_if.bus_err, 0);
    chk("race err_id", bus_if.err_id, 3);
    bus_if.DMA = 8'h02;
    tick();
    chk("race regrant", bus_if.grant, 8'h02);
    chk("race no err2", bus_if.bus_err, 0);

    // async reset mid-cycle while master 1 owns the bus
    #3;
    clr_n = 1'b0;
    #1;
    $display("async reset grant=%02h req=%0d", bus_if.grant, bus_if.BUS_req);
    chk("arst grant", bus_if.grant, 0);
    chk("arst req", bus_if.BUS_req, 0);
    chk("arst owner", bus_if.owner, 0);
    chk("arst err_id", bus_if.err_id, 0);
    bus_if.DMA       = 8'h22;
    bus_if.BUS_ready = 1'b1;
    #2;
    clr_n = 1'b1;
    tick();
    chk("arst first", bus_if.grant, 8'h02);
    chk("arst owner1", bus_if.owner, 1);
    bus_if.DMA = 8'h20;
    tick();
    chk("arst rel", bus_if.grant, 0);
    tick();
    chk("arst second", bus_if.grant, 8'h20);
    chk("arst owner5", bus_if.owner, 5);
    bus_if.DMA = 8'h00;
    tick();
    chk("arst end", bus_if.grant, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
